// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu_64bit program-image loader.
// The loader state enum includes CSUM, which is only reachable when IMEM_LOADER_CHECKSUM_EN is defined.
package cpu_pkg;

    localparam int INSTR_W            = 32;
    localparam int IMEM_DEPTH_DEFAULT = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_FLUSH,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/imem_stream_loader_packer.sv
// imem_word_packer: gathers four stream bytes into one little-endian instruction word.
// word_valid pulses for one cycle after the fourth byte lands.
module imem_word_packer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               last_lane,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word
);

    logic [1:0] lane_reg;
    logic       word_valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_reg       <= 2'd0;
            word_valid_reg <= 1'b0;
        end else begin
            word_valid_reg <= 1'b0;
            if (clear) begin
                lane_reg <= 2'd0;
            end else if (byte_valid) begin
                lane_reg       <= lane_reg + 2'd1;
                word_valid_reg <= (lane_reg == 2'd3);
            end
        end
    end

    // Each lane owns its own byte register so lane k lands in word[8k+7:8k].
    for (genvar gi = 0; gi < INSTR_W / 8; gi++) begin : gen_lane
        logic [7:0] byte_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                byte_reg <= 8'd0;
            end else if (byte_valid && !clear && (lane_reg == 2'(gi))) begin
                byte_reg <= byte_data;
            end
        end

        assign word[8*gi +: 8] = byte_reg;
    end

    assign last_lane  = (lane_reg == 2'd3);
    assign word_valid = word_valid_reg;

endmodule

// File: rtl/imem_stream_loader.sv
// Loads a length-prefixed byte stream into cpu_64bit instruction memory while holding the CPU in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_stream_loader
    import cpu_pkg::*;
#(
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
    parameter int ADDR_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               load_done,
    output logic               load_error,
    output logic [15:0]        words_loaded
);

    loader_state_t     state_reg;
    logic [15:0]       len_reg;
    logic [15:0]       words_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              in_ready_reg;
    logic              cpu_hold_reg;
    logic              load_done_reg;
    logic              load_error_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_reg;
`endif

    logic        accept;
    logic        armable;
    logic [15:0] len_full;
    logic [15:0] words_next;
    logic        last_word;
    logic        last_lane;
    logic        word_valid;

    assign accept     = in_valid && in_ready_reg;
    assign armable    = (state_reg == ST_IDLE) || (state_reg == ST_DONE) || (state_reg == ST_ERROR);
    assign len_full   = {in_data, len_reg[7:0]};
    assign words_next = (words_reg == 16'(IMEM_DEPTH)) ? words_reg : words_reg + 16'd1;
    assign last_word  = (words_reg + 16'd1 == len_reg);

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start && armable),
        .byte_valid (accept && (state_reg == ST_DATA)),
        .byte_data  (in_data),
        .last_lane  (last_lane),
        .word_valid (word_valid),
        .word       (imem_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            len_reg        <= 16'd0;
            words_reg      <= 16'd0;
            addr_reg       <= '0;
            in_ready_reg   <= 1'b0;
            cpu_hold_reg   <= 1'b1;
            load_done_reg  <= 1'b0;
            load_error_reg <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg       <= 8'd0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_reg      <= ST_LEN_LO;
                        len_reg        <= 16'd0;
                        words_reg      <= 16'd0;
                        addr_reg       <= '0;
                        in_ready_reg   <= 1'b1;
                        cpu_hold_reg   <= 1'b1;
                        load_done_reg  <= 1'b0;
                        load_error_reg <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_reg       <= 8'd0;
`endif
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        len_reg[7:0] <= in_data;
                        state_reg    <= ST_LEN_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_reg     <= csum_reg ^ in_data;
`endif
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        len_reg[15:8] <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_reg      <= csum_reg ^ in_data;
`endif
                        if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_reg     <= ST_CSUM;
`else
                            state_reg     <= ST_DONE;
                            in_ready_reg  <= 1'b0;
                            cpu_hold_reg  <= 1'b0;
                            load_done_reg <= 1'b1;
`endif
                        end else if (len_full > 16'(IMEM_DEPTH)) begin
                            state_reg      <= ST_ERROR;
                            in_ready_reg   <= 1'b0;
                            load_error_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_reg <= csum_reg ^ in_data;
`endif
                        // Count the word now so the new total is visible alongside its strobe.
                        if (last_lane) begin
                            words_reg <= words_next;
                            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_reg    <= ST_CSUM;
`else
                                state_reg    <= ST_FLUSH;
                                in_ready_reg <= 1'b0;
`endif
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    state_reg     <= ST_DONE;
                    cpu_hold_reg  <= 1'b0;
                    load_done_reg <= 1'b1;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (accept) begin
                        in_ready_reg <= 1'b0;
                        if (in_data == csum_reg) begin
                            state_reg     <= ST_DONE;
                            cpu_hold_reg  <= 1'b0;
                            load_done_reg <= 1'b1;
                        end else begin
                            state_reg      <= ST_ERROR;
                            load_error_reg <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_reg    <= ST_IDLE;
                    in_ready_reg <= 1'b0;
                end
            endcase

            // A strobe never coincides with arming, so this cannot fight the clear above.
            if (word_valid) begin
                addr_reg <= addr_reg + ADDR_W'(1);
            end
        end
    end

    assign in_ready     = in_ready_reg;
    assign imem_we      = word_valid;
    assign imem_addr    = addr_reg;
    assign cpu_hold     = cpu_hold_reg;
    assign load_done    = load_done_reg;
    assign load_error   = load_error_reg;
    assign words_loaded = words_reg;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader; frames carry a trailing checksum when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_stream_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    imem_stream_loader #(.IMEM_DEPTH(256), .ADDR_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          strobes = 0;
    int          last_we_cyc = 0;
    int          done_cyc = 0;
    logic        hold_at_we = 1'b0;
    logic        prev_done = 1'b0;
    logic [31:0] tb_mem [0:255];
    logic [31:0] fw [0:3];
    int          n_checks = 0;
    int          n_err = 0;
    int          s0;

    always @(posedge clk) cyc++;

    // Observe writes mid-cycle so the captured values are the settled ones.
    always @(negedge clk) begin
        if (imem_we) begin
            tb_mem[imem_addr] = imem_wdata;
            strobes++;
            last_we_cyc = cyc;
            hold_at_we = cpu_hold;
        end
        if (load_done && !prev_done) done_cyc = cyc;
        prev_done = load_done;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gapped);
        int n = 0;
        if (gapped) begin
            in_valid = 1'b0;
            tick($urandom_range(0, 2));
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            tick(1);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit gapped, input bit corrupt);
        logic [7:0]  x;
        logic [15:0] len;
        logic [31:0] w;
        len = n[15:0];
        x = len[7:0] ^ len[15:8];
        send_byte(len[7:0], gapped);
        send_byte(len[15:8], gapped);
        for (int i = 0; i < n; i++) begin
            w = fw[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], gapped);
                x = x ^ w[8*k +: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(x ^ {7'd0, corrupt}, gapped);
`endif
        $display("frame words=%0d gapped=%0d corrupt=%0d xor=%h strobes=%0d", n, gapped, corrupt, x, strobes);
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(load_done || load_error) && n < 30) begin
            tick(1);
            n++;
        end
        if (!(load_done || load_error)) check("end_timeout", {31'd0, load_done | load_error}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 8'h00;
        tick(2);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_imem_we", {31'd0, imem_we}, 32'd0);
        check("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_load_error", {31'd0, load_error}, 32'd0);
        check("rst_words", {16'd0, words_loaded}, 32'd0);
        rst = 1'b0;
        tick(3);
        check("idle_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;

        // Two-word load
        fw[0] = 32'h00500093; fw[1] = 32'h00800113;
        s0 = strobes;
        pulse_start();
        send_frame(2, 1'b0, 1'b0);
        wait_end();
        tick(1);
        check("two_mem0", tb_mem[0], 32'h00500093);
        check("two_mem1", tb_mem[1], 32'h00800113);
        check("two_strobes", strobes - s0, 32'd2);
        check("two_words", {16'd0, words_loaded}, 32'd2);
        check("two_done", {31'd0, load_done}, 32'd1);
        check("two_hold", {31'd0, cpu_hold}, 32'd0);
        check("two_done_latency", done_cyc - last_we_cyc, 32'd1);
        check("two_hold_at_strobe", {31'd0, hold_at_we}, 32'd1);

        // Zero length
        s0 = strobes;
        pulse_start();
        check("zero_armed_done_clr", {31'd0, load_done}, 32'd0);
        send_frame(0, 1'b0, 1'b0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("zero_done_immediate", {31'd0, load_done}, 32'd1);
`endif
        wait_end();
        check("zero_strobes", strobes - s0, 32'd0);
        check("zero_done", {31'd0, load_done}, 32'd1);
        check("zero_hold", {31'd0, cpu_hold}, 32'd0);
        in_valid = 1'b1;
        tick(4);
        check("done_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        check("done_no_strobe", strobes - s0, 32'd0);

        // Oversize
        s0 = strobes;
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        tick(1);
        check("over_error", {31'd0, load_error}, 32'd1);
        check("over_hold", {31'd0, cpu_hold}, 32'd1);
        check("over_done", {31'd0, load_done}, 32'd0);
        check("over_strobes", strobes - s0, 32'd0);
        check("over_in_ready", {31'd0, in_ready}, 32'd0);
        pulse_start();
        check("rearm_error_clr", {31'd0, load_error}, 32'd0);
        check("rearm_in_ready", {31'd0, in_ready}, 32'd1);
        check("rearm_hold", {31'd0, cpu_hold}, 32'd1);

        // Gapped three-word load on the re-armed loader
        fw[0] = 32'h11223344; fw[1] = 32'hdeadbeef; fw[2] = 32'h00000013;
        send_frame(3, 1'b1, 1'b0);
        wait_end();
        tick(1);
        check("gap_mem0", tb_mem[0], 32'h11223344);
        check("gap_mem1", tb_mem[1], 32'hdeadbeef);
        check("gap_mem2", tb_mem[2], 32'h00000013);
        check("gap_words", {16'd0, words_loaded}, 32'd3);
        check("gap_done", {31'd0, load_done}, 32'd1);

        // Reset mid-load, with an ignored start in the middle of the data
        s0 = strobes;
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hdd, 1'b0);
        send_byte(8'hcc, 1'b0);
        pulse_start();
        send_byte(8'hbb, 1'b0);
        send_byte(8'haa, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h03, 1'b0);
        tick(1);
        check("mid_mem0", tb_mem[0], 32'haabbccdd);
        check("mid_words", {16'd0, words_loaded}, 32'd1);
        check("mid_addr", {24'd0, imem_addr}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_hold", {31'd0, cpu_hold}, 32'd1);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_words", {16'd0, words_loaded}, 32'd0);
        check("mid_rst_addr", {24'd0, imem_addr}, 32'd0);
        check("mid_rst_wdata", imem_wdata, 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
        fw[0] = 32'hcafef00d; fw[1] = 32'h12345678;
        pulse_start();
        send_frame(2, 1'b0, 1'b0);
        wait_end();
        tick(1);
        check("post_rst_mem0", tb_mem[0], 32'hcafef00d);
        check("post_rst_mem1", tb_mem[1], 32'h12345678);
        check("post_rst_done", {31'd0, load_done}, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        fw[0] = 32'h0badc0de; fw[1] = 32'h00000073;
        pulse_start();
        send_frame(2, 1'b0, 1'b0);
        wait_end();
        check("csum_ok_done", {31'd0, load_done}, 32'd1);
        check("csum_ok_error", {31'd0, load_error}, 32'd0);
        s0 = strobes;
        pulse_start();
        send_frame(2, 1'b0, 1'b1);
        wait_end();
        tick(1);
        check("csum_bad_error", {31'd0, load_error}, 32'd1);
        check("csum_bad_hold", {31'd0, cpu_hold}, 32'd1);
        check("csum_bad_strobes", strobes - s0, 32'd2);
        check("csum_bad_done", {31'd0, load_done}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
